// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module : fetch_pkg
// Brief  : Shared types and constants for the LEGv8 fetch front end.
// Rev    : 1.0
// ============================================================================
package fetch_pkg;

  localparam int INSTR_W    = 32;
  localparam int OP_W       = 11;
  localparam int PC_INC     = 4;
  localparam int FIFO_DEPTH = 2;
  localparam int ENTRY_PC_W = 64;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0]    instr;
    logic [ENTRY_PC_W-1:0] pc;
  } fetch_entry_t;

  function automatic logic [OP_W-1:0] op_field(input logic [INSTR_W-1:0] i_word);
    return i_word[31:21];
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module : fetch_fifo
// Brief  : Two-entry registered FIFO of fetched {instr, pc}; head is zero when empty.
// Rev    : 1.0
// ============================================================================
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  fetch_entry_t i_push_entry,
  input  logic         i_pop,
  input  logic         i_flush,
  output logic [1:0]   o_count,
  output fetch_entry_t o_head
);

  fetch_entry_t r_mem [FIFO_DEPTH];
  logic         r_rd_ptr;
  logic         r_wr_ptr;
  logic [1:0]   r_count;
  logic         w_push;
  logic         w_pop;

  assign w_pop  = i_pop && (r_count != 2'd0);
  assign w_push = i_push && ((r_count != 2'(FIFO_DEPTH)) || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
    end else if (w_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_push_entry;
    end
  end

  assign o_count = r_count;
  assign o_head  = (r_count != 2'd0) ? r_mem[r_rd_ptr] : '0;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : fetch_unit
// Brief  : LEGv8 instruction fetch: PC, imem valid/ready requests, 2-entry buffer.
// Config : FETCH_PERF_CNT_EN adds fetch_cnt / flush_cnt performance outputs.
// Rev    : 1.0
// ============================================================================
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned  N        = 64,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  output logic [N-1:0]       imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [N-1:0]       redirect_pc,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [N-1:0]       instr_pc,
  input  logic               instr_ready,
  output logic [OP_W-1:0]    Op
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        flush_cnt
`endif
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [N-1:0] r_pc;
  logic [N-1:0] r_req_addr;
  logic         r_run;
  logic         w_accept;
  logic         w_push;
  logic         w_pop;
  logic         w_discard;
  logic [1:0]   w_count;
  fetch_entry_t w_head;
  fetch_entry_t w_push_entry;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= REQ;
    else       r_state <= w_state_nxt;
  end

  // Redirect suppresses new requests and turns any in-flight response into a discard.
  always_comb begin
    w_state_nxt    = r_state;
    imem_req_valid = 1'b0;
    w_push         = 1'b0;
    w_discard      = 1'b0;
    case (r_state)
      REQ: begin
        imem_req_valid = r_run && (w_count < 2'(FIFO_DEPTH)) && !redirect_valid;
        if (imem_req_valid && imem_req_ready) w_state_nxt = WAIT;
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          w_state_nxt = REQ;
          w_push      = !redirect_valid;
          w_discard   = redirect_valid;
        end else if (redirect_valid) begin
          w_state_nxt = DROP;
        end
      end
      DROP: begin
        if (imem_rsp_valid) begin
          w_state_nxt = REQ;
          w_discard   = 1'b1;
        end
      end
      default: w_state_nxt = REQ;
    endcase
  end

  assign w_accept = imem_req_valid && imem_req_ready;

  // r_run holds requests off for the first cycle after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_req_addr <= '0;
      r_run      <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (redirect_valid) begin
        r_pc <= {redirect_pc[N-1:2], 2'b00};
      end else if (w_accept) begin
        r_pc       <= r_pc + N'(PC_INC);
        r_req_addr <= r_pc;
      end
    end
  end

  assign w_push_entry = '{instr: imem_rsp_data, pc: ENTRY_PC_W'(r_req_addr)};

  fetch_fifo u_fifo (
    .clk          (clk),
    .rst          (reset),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .i_flush      (redirect_valid),
    .o_count      (w_count),
    .o_head       (w_head)
  );

  assign imem_req_addr = r_pc;
  assign instr_valid   = (w_count != 2'd0) && !redirect_valid;
  assign w_pop         = instr_valid && instr_ready;
  assign instr         = w_head.instr;
  assign instr_pc      = w_head.pc[N-1:0];
  assign Op            = op_field(w_head.instr);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_flush_cnt;
  logic [31:0] w_flush_add;

  assign w_flush_add = (redirect_valid ? 32'(w_count) : 32'd0) + (w_discard ? 32'd1 : 32'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      if (w_pop) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      r_flush_cnt <= r_flush_cnt + w_flush_add;
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  // Performance counters are compiled out in this build.
`endif

endmodule
`default_nettype wire
